// File: rtl/lock_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lock_ctrl_if
// Purpose  : Bundles the key/tick inputs and the display/bolt outputs of the
//            lock controller.
// Revision : 1.0 - initial release
// Signals  : hz1      1 Hz single-cycle tick
//            keyvalid single-cycle key strobe
//            key      key code (0-9 digit, a CLEAR, b ENTER, c SET)
//            dig4     status glyph code
//            dig3..0  digit codes (dig0 rightmost)
//            dispen   per-digit display enable, bit4 = dig4
//            lock     1 = bolt engaged
// Modports : master - key decoder / tick source side (drives inputs)
//            slave  - lock controller side (drives display and bolt)
//------------------------------------------------------------------------------
interface lock_ctrl_if;
  logic       hz1;
  logic       keyvalid;
  logic [3:0] key;
  logic [3:0] dig4;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [4:0] dispen;
  logic       lock;

  modport master (
    output hz1, keyvalid, key,
    input  dig4, dig3, dig2, dig1, dig0, dispen, lock
  );

  modport slave (
    input  hz1, keyvalid, key,
    output dig4, dig3, dig2, dig1, dig0, dispen, lock
  );
endinterface
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lock_ctrl
// Purpose  : Keypad entry and access-code check for the electronic lock.
//            Sequences LOCKED / OPEN / SET / ERROR with 1 Hz timed dwell and
//            drives the 5-digit multiplexed display stage.
// Revision : 1.0 - initial release
// Ports    : ck     in  system clock
//            reset  in  asynchronous, active-high reset
//            bus    lock_ctrl_if.slave (hz1, keyvalid, key in;
//                   dig4..dig0, dispen, lock out)
// Params   : INIT_CODE  4-digit BCD code loaded at reset (dig3 = MS digit)
//            OPEN_SEC   OPEN dwell in seconds (1-9)
//            ERR_SEC    ERROR dwell in seconds (1-9)
// Macro    : LOCKOUT_EN - adds a consecutive-fail counter; the third and
//            later consecutive failures hold ERROR for 9 s and show the
//            countdown on dig0.
//------------------------------------------------------------------------------
module lock_ctrl #(
  parameter logic [15:0] INIT_CODE = 16'h1234,
  parameter int unsigned OPEN_SEC  = 5,
  parameter int unsigned ERR_SEC   = 3
) (
  input  wire logic   ck,
  input  wire logic   reset,
  lock_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SET    = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] c_KEY_CLEAR = 4'ha;
  localparam logic [3:0] c_KEY_ENTER = 4'hb;
  localparam logic [3:0] c_KEY_SET   = 4'hc;
  localparam logic [3:0] c_GLY_L     = 4'hb;
  localparam logic [3:0] c_GLY_C     = 4'hc;
  localparam logic [3:0] c_GLY_N     = 4'hd;
  localparam logic [3:0] c_GLY_E     = 4'he;
  localparam logic [3:0] c_GLY_DASH  = 4'ha;
  localparam logic [3:0] c_OPEN_T    = 4'(OPEN_SEC);
  localparam logic [3:0] c_ERR_T     = 4'(ERR_SEC);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_entry, w_entry_nxt;
  logic [2:0]  r_cnt,   w_cnt_nxt;
  logic [15:0] r_code,  w_code_nxt;
  logic [3:0]  r_timer, w_timer_nxt;

  logic        w_is_digit;
  logic [3:0]  w_err_timer;
  logic [3:0]  w_cnt_mask;

`ifdef LOCKOUT_EN
  logic [1:0]  r_fail, w_fail_nxt;
  // The failure being recorded now is the third (or later) in a row.
  assign w_err_timer = (r_fail >= 2'd2) ? 4'd9 : c_ERR_T;
`else
  assign w_err_timer = c_ERR_T;
`endif

  assign w_is_digit = (bus.key <= 4'd9);

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCKED;
      r_entry <= 16'h0000;
      r_cnt   <= 3'd0;
      r_code  <= INIT_CODE;
      r_timer <= 4'd0;
`ifdef LOCKOUT_EN
      r_fail  <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_entry <= w_entry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_timer <= w_timer_nxt;
`ifdef LOCKOUT_EN
      r_fail  <= w_fail_nxt;
`endif
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic. A key strobe wins over a coincident tick; the tick is
  // simply dropped in that cycle.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_timer_nxt = r_timer;

    if (bus.keyvalid) begin
      unique case (r_state)
        ST_LOCKED, ST_SET: begin
          if (w_is_digit) begin
            if (r_cnt < 3'd4) begin
              w_entry_nxt = {r_entry[11:0], bus.key};
              w_cnt_nxt   = r_cnt + 3'd1;
            end
          end else if (bus.key == c_KEY_CLEAR) begin
            w_entry_nxt = 16'h0000;
            w_cnt_nxt   = 3'd0;
          end else if (bus.key == c_KEY_ENTER) begin
            w_entry_nxt = 16'h0000;
            w_cnt_nxt   = 3'd0;
            if (r_state == ST_LOCKED) begin
              if ((r_cnt == 3'd4) && (r_entry == r_code)) begin
                w_state_nxt = ST_OPEN;
                w_timer_nxt = c_OPEN_T;
              end else begin
                w_state_nxt = ST_ERROR;
                w_timer_nxt = w_err_timer;
              end
            end else begin
              if (r_cnt == 3'd4) begin
                w_code_nxt  = r_entry;
                w_state_nxt = ST_LOCKED;
              end else begin
                w_state_nxt = ST_ERROR;
                w_timer_nxt = w_err_timer;
              end
            end
          end
        end
        ST_OPEN: begin
          if (bus.key == c_KEY_ENTER) begin
            w_state_nxt = ST_LOCKED;
          end else if (bus.key == c_KEY_SET) begin
            w_state_nxt = ST_SET;
            w_entry_nxt = 16'h0000;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: ; // ERROR ignores every key
      endcase
    end else if (bus.hz1 && ((r_state == ST_OPEN) || (r_state == ST_ERROR))) begin
      // timer==0 cannot occur in a timed state; treat it as expiry anyway.
      if (r_timer <= 4'd1) begin
        w_state_nxt = ST_LOCKED;
        w_timer_nxt = 4'd0;
      end else begin
        w_timer_nxt = r_timer - 4'd1;
      end
    end
  end

`ifdef LOCKOUT_EN
  always_comb begin
    w_fail_nxt = r_fail;
    if ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR) && (r_fail != 2'd3)) begin
      w_fail_nxt = r_fail + 2'd1;
    end else if ((w_state_nxt == ST_OPEN) && (r_state == ST_LOCKED)) begin
      w_fail_nxt = 2'd0;
    end
  end
`endif

  //--------------------------------------------------------------------------
  // Display and bolt decode, purely from registered state
  //--------------------------------------------------------------------------
  // Entered digits light from the right as the count grows.
  always_comb begin
    w_cnt_mask = 4'b0000;
    case (r_cnt)
      3'd0:    w_cnt_mask = 4'b0000;
      3'd1:    w_cnt_mask = 4'b0001;
      3'd2:    w_cnt_mask = 4'b0011;
      3'd3:    w_cnt_mask = 4'b0111;
      default: w_cnt_mask = 4'b1111;
    endcase
  end

  always_comb begin
    bus.lock   = 1'b1;
    bus.dig4   = c_GLY_L;
    bus.dig3   = r_entry[15:12];
    bus.dig2   = r_entry[11:8];
    bus.dig1   = r_entry[7:4];
    bus.dig0   = r_entry[3:0];
    bus.dispen = {1'b1, w_cnt_mask};
    unique case (r_state)
      ST_LOCKED: ;
      ST_SET: begin
        bus.lock = 1'b0;
        bus.dig4 = c_GLY_C;
      end
      ST_OPEN: begin
        bus.lock   = 1'b0;
        bus.dig4   = c_GLY_N;
        bus.dig3   = 4'h0;
        bus.dig2   = 4'h0;
        bus.dig1   = 4'h0;
        bus.dig0   = r_timer;
        bus.dispen = 5'b10001;
      end
      default: begin
        bus.dig4   = c_GLY_E;
        bus.dig3   = c_GLY_DASH;
        bus.dig2   = c_GLY_DASH;
        bus.dig1   = c_GLY_DASH;
        bus.dig0   = c_GLY_DASH;
        bus.dispen = 5'b11111;
`ifdef LOCKOUT_EN
        if (r_fail == 2'd3) begin
          bus.dig0 = r_timer;
        end
`endif
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_lock_ctrl
// Purpose  : Directed self-checking bench for lock_ctrl. Observed value is
//            {lock, dig4, dig3, dig2, dig1, dig0, dispen}.
// Revision : 1.0 - initial release
// Macro    : LOCKOUT_EN selects the lockout expectations in test_lockout.
//------------------------------------------------------------------------------
module tb_lock_ctrl;

  logic ck;
  logic reset;
  int   n_cmp;
  int   n_bad;

  lock_ctrl_if u_if ();

  lock_ctrl #(
    .INIT_CODE (16'h1234),
    .OPEN_SEC  (5),
    .ERR_SEC   (3)
  ) u_dut (
    .ck    (ck),
    .reset (reset),
    .bus   (u_if.slave)
  );

  logic [25:0] w_obs;
  assign w_obs = {u_if.lock, u_if.dig4, u_if.dig3, u_if.dig2, u_if.dig1, u_if.dig0, u_if.dispen};

  localparam logic [25:0] c_LOCKED0 = {1'b1, 4'hb, 16'h0000, 5'b10000};
  localparam logic [25:0] c_ERR     = {1'b1, 4'he, 16'haaaa, 5'b11111};

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Inputs change on the falling edge; outputs are sampled on the following
  // falling edge, half a period after the edge that consumed the input.
  task automatic press(input logic [3:0] k);
    @(negedge ck);
    u_if.keyvalid = 1'b1;
    u_if.key      = k;
    @(negedge ck);
    u_if.keyvalid = 1'b0;
    u_if.key      = 4'h0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ck);
      u_if.hz1 = 1'b1;
      @(negedge ck);
      u_if.hz1 = 1'b0;
    end
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
    press(4'hb);
  endtask

  task automatic test_reset;
    u_if.hz1 = 1'b0; u_if.keyvalid = 1'b0; u_if.key = 4'h0;
    reset = 1'b1;
    repeat (3) @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL reset: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  task automatic test_open;
    press(4'h1);
    if (w_obs !== {1'b1, 4'hb, 16'h0001, 5'b10001}) begin n_bad++; $display("FAIL open_d1: got %h required %h", w_obs, {1'b1, 4'hb, 16'h0001, 5'b10001}); end
    n_cmp++;
    press(4'h2);
    if (w_obs !== {1'b1, 4'hb, 16'h0012, 5'b10011}) begin n_bad++; $display("FAIL open_d2: got %h required %h", w_obs, {1'b1, 4'hb, 16'h0012, 5'b10011}); end
    n_cmp++;
    press(4'h3);
    if (w_obs !== {1'b1, 4'hb, 16'h0123, 5'b10111}) begin n_bad++; $display("FAIL open_d3: got %h required %h", w_obs, {1'b1, 4'hb, 16'h0123, 5'b10111}); end
    n_cmp++;
    press(4'h4);
    if (w_obs !== {1'b1, 4'hb, 16'h1234, 5'b11111}) begin n_bad++; $display("FAIL open_d4: got %h required %h", w_obs, {1'b1, 4'hb, 16'h1234, 5'b11111}); end
    n_cmp++;
    press(4'hb);
    if (w_obs !== {1'b0, 4'hd, 16'h0005, 5'b10001}) begin n_bad++; $display("FAIL open_enter: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0005, 5'b10001}); end
    n_cmp++;
    tick(4);
    if (w_obs !== {1'b0, 4'hd, 16'h0001, 5'b10001}) begin n_bad++; $display("FAIL open_t1: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0001, 5'b10001}); end
    n_cmp++;
    tick(1);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL open_timeout: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  task automatic test_error;
    press(4'h1); press(4'h2); press(4'h3); press(4'hb);
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL err_enter: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    press(4'h7); press(4'ha);
    tick(2);
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL err_hold: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    tick(1);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL err_timeout: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  task automatic test_overflow;
    press(4'hc);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL set_in_locked: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'he);
    if (w_obs !== {1'b1, 4'hb, 16'h1234, 5'b11111}) begin n_bad++; $display("FAIL ovf_5th: got %h required %h", w_obs, {1'b1, 4'hb, 16'h1234, 5'b11111}); end
    n_cmp++;
    press(4'ha);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL ovf_clear: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  task automatic test_set_code;
    enter_code(16'h1234);
    press(4'hc);
    if (w_obs !== {1'b0, 4'hc, 16'h0000, 5'b10000}) begin n_bad++; $display("FAIL set_enter: got %h required %h", w_obs, {1'b0, 4'hc, 16'h0000, 5'b10000}); end
    n_cmp++;
    tick(2);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    if (w_obs !== {1'b0, 4'hc, 16'h9876, 5'b11111}) begin n_bad++; $display("FAIL set_digits: got %h required %h", w_obs, {1'b0, 4'hc, 16'h9876, 5'b11111}); end
    n_cmp++;
    press(4'hb);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL set_store: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
    enter_code(16'h1234);
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL set_old_code: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    tick(3);
    enter_code(16'h9876);
    if (w_obs !== {1'b0, 4'hd, 16'h0005, 5'b10001}) begin n_bad++; $display("FAIL set_new_code: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0005, 5'b10001}); end
    n_cmp++;
    // Short entry in SET must fail and keep the stored code.
    press(4'hc); press(4'h1); press(4'h2); press(4'hb);
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL set_short: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    tick(3);
    enter_code(16'h9876);
    if (w_obs !== {1'b0, 4'hd, 16'h0005, 5'b10001}) begin n_bad++; $display("FAIL set_code_kept: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0005, 5'b10001}); end
    n_cmp++;
    press(4'hb);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL open_enter_lock: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  task automatic test_collision_and_reset;
    enter_code(16'h9876);
    tick(4);
    @(negedge ck);
    u_if.keyvalid = 1'b1; u_if.key = 4'hc; u_if.hz1 = 1'b1;
    @(negedge ck);
    u_if.keyvalid = 1'b0; u_if.key = 4'h0; u_if.hz1 = 1'b0;
    if (w_obs !== {1'b0, 4'hc, 16'h0000, 5'b10000}) begin n_bad++; $display("FAIL key_over_tick: got %h required %h", w_obs, {1'b0, 4'hc, 16'h0000, 5'b10000}); end
    n_cmp++;
    press(4'h5);
    @(negedge ck);
    #2 reset = 1'b1;
    #1;
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL async_reset: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
    @(negedge ck);
    reset = 1'b0;
    enter_code(16'h1234);
    if (w_obs !== {1'b0, 4'hd, 16'h0005, 5'b10001}) begin n_bad++; $display("FAIL reset_code: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0005, 5'b10001}); end
    n_cmp++;
    press(4'hb);
  endtask

  task automatic test_lockout;
    enter_code(16'h0000); tick(3);
    enter_code(16'h0000); tick(3);
    enter_code(16'h0000);
`ifdef LOCKOUT_EN
    if (w_obs !== {1'b1, 4'he, 16'haaa9, 5'b11111}) begin n_bad++; $display("FAIL lockout_third: got %h required %h", w_obs, {1'b1, 4'he, 16'haaa9, 5'b11111}); end
    n_cmp++;
    tick(8);
    if (w_obs !== {1'b1, 4'he, 16'haaa1, 5'b11111}) begin n_bad++; $display("FAIL lockout_hold: got %h required %h", w_obs, {1'b1, 4'he, 16'haaa1, 5'b11111}); end
    n_cmp++;
    tick(1);
`else
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL third_err: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    tick(3);
`endif
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL third_timeout: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
    enter_code(16'h1234);
    if (w_obs !== {1'b0, 4'hd, 16'h0005, 5'b10001}) begin n_bad++; $display("FAIL after_lockout_open: got %h required %h", w_obs, {1'b0, 4'hd, 16'h0005, 5'b10001}); end
    n_cmp++;
    press(4'hb);
    // A fresh failure after success uses the normal 3 s dash display.
    enter_code(16'h0000);
    if (w_obs !== c_ERR) begin n_bad++; $display("FAIL fail_cleared: got %h required %h", w_obs, c_ERR); end
    n_cmp++;
    tick(3);
    if (w_obs !== c_LOCKED0) begin n_bad++; $display("FAIL fail_cleared_timeout: got %h required %h", w_obs, c_LOCKED0); end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset;
    test_open;
    test_error;
    test_overflow;
    test_set_code;
    test_collision_and_reset;
    test_lockout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
